// File: rtl/aes_ctrl_seq_pkg.sv
// Shared definitions for the AES round-control sequencer and its control-signal decoder.
// The state codes are part of the interface contract, so both stages take them from here.
package aes_ctrl_seq_pkg;

  typedef enum logic [3:0] {
    S0 = 4'b0000,  // idle
    S1 = 4'b0001,  // encrypt load
    S2 = 4'b0010,  // encrypt main round
    S3 = 4'b0011,  // encrypt final round
    S4 = 4'b0100,  // decrypt load
    S5 = 4'b0101,  // decrypt first round
    S6 = 4'b0110,  // decrypt main round
    S7 = 4'b0111,  // decrypt final round
    S8 = 4'b1000,  // ciphertext out
    S9 = 4'b1001   // plaintext out
  } state_t;

  localparam int NR_DEFAULT = 10;
  localparam int NR_MIN     = 2;
  localparam int NR_MAX     = 15;

  function automatic logic is_output_state(input state_t s);
    return (s == S8) || (s == S9);
  endfunction

endpackage

// File: rtl/aes_ctrl_seq.sv
// AES round-control sequencer: walks the load / round / final / output states for
// encrypt or decrypt and exposes the registered state code and round counter.
module aes_ctrl_seq
  import aes_ctrl_seq_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       out_ack,
  output logic [3:0] Q,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  if (NR < NR_MIN || NR > NR_MAX) begin : g_bad_nr
    $error("aes_ctrl_seq: NR must be within 2..15");
  end

  localparam logic [3:0] LP_NR    = 4'(NR);
  localparam logic [3:0] LP_NR_M1 = 4'(NR - 1);

  state_t     r_state;
  logic [3:0] r_round;

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below reads the pre-edge r_state/r_round regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S0;
      r_round <= '0;
    end else begin
      case (r_state)
        S0: begin
          r_round <= '0;
          if (start) r_state <= mode ? S4 : S1;
        end
        S1: begin
          r_state <= S2;
          r_round <= 4'd1;
        end
        S2, S6: begin
          if (r_round < LP_NR_M1) begin
            r_round <= r_round + 4'd1;
          end else begin
            r_state <= (r_state == S2) ? S3 : S7;
            r_round <= LP_NR;
          end
        end
        S3: r_state <= S8;
        S4: begin
          r_state <= S5;
          r_round <= 4'd1;
        end
        S5: begin
          // With only two rounds there is no main round between first and final.
          if (LP_NR == 4'd2) begin
            r_state <= S7;
            r_round <= LP_NR;
          end else begin
            r_state <= S6;
            r_round <= 4'd2;
          end
        end
        S7: r_state <= S9;
        S8, S9: begin
          if (out_ack) begin
            r_state <= S0;
            r_round <= '0;
          end
        end
        // NOTE: codes 1010..1111 are unreachable in normal operation; the default
        // branch makes any upset recover to idle in one edge instead of locking up.
        default: begin
          r_state <= S0;
          r_round <= '0;
        end
      endcase
    end
  end

  assign Q     = r_state;
  assign round = r_round;
  assign busy  = (r_state != S0);
  assign done  = is_output_state(r_state);

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// Self-checking bench for aes_ctrl_seq: two instances (NR=10 and NR=2) share the
// stimulus and are compared against an operation-progress model each cycle.
module tb_aes_ctrl_seq;
  import aes_ctrl_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, mode = 1'b0, out_ack = 1'b0;
  logic [3:0] q_a, round_a, q_b, round_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic [9:0] obs_a, obs_b;

  int checks = 0;
  int failures = 0;

  aes_ctrl_seq #(.NR(10)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .out_ack(out_ack),
    .Q(q_a), .round(round_a), .busy(busy_a), .done(done_a)
  );

  aes_ctrl_seq #(.NR(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .out_ack(out_ack),
    .Q(q_b), .round(round_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  assign obs_a = {q_a, round_a, busy_a, done_a};
  assign obs_b = {q_b, round_b, busy_b, done_b};

  // Reference: an accepted operation is just "cycles since start" plus direction.
  typedef struct {
    bit active;
    bit dec;
    int cnt;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t model_step(input mdl_t m, input int nr,
                                      input bit s, input bit md, input bit ack);
    mdl_t n = m;
    if (!m.active) begin
      if (s) begin
        n.active = 1'b1;
        n.dec    = md;
        n.cnt    = 0;
      end
    end else if (m.cnt <= nr) begin
      n.cnt = m.cnt + 1;
    end else if (ack) begin
      n.active = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [9:0] model_obs(input mdl_t m, input int nr);
    logic [3:0] q;
    logic [3:0] rnd;
    if (!m.active)          begin q = 4'd0;                   rnd = 4'd0;        end
    else if (m.cnt > nr)    begin q = m.dec ? 4'd9 : 4'd8;    rnd = 4'(nr);      end
    else if (m.cnt == nr)   begin q = m.dec ? 4'd7 : 4'd3;    rnd = 4'(nr);      end
    else if (m.cnt == 0)    begin q = m.dec ? 4'd4 : 4'd1;    rnd = 4'd0;        end
    else if (m.dec && m.cnt == 1) begin q = 4'd5;             rnd = 4'd1;        end
    else                    begin q = m.dec ? 4'd6 : 4'd2;    rnd = 4'(m.cnt);   end
    return {q, rnd, m.active, (m.active && m.cnt > nr)};
  endfunction

  task automatic tick(input logic s, input logic md, input logic ack);
    start   = s;
    mode    = md;
    out_ack = ack;
    @(posedge clk);
    ma = model_step(ma, 10, s, md, ack);
    mb = model_step(mb, 2, s, md, ack);
    #1;
  endtask

  task automatic test_reset();
    ma = '{default: 0};
    mb = '{default: 0};
    #2;
    checks++;
    if ({obs_a, obs_b} !== 20'd0) begin
      failures++;
      $display("FAIL reset_state got a=%h b=%h exp 000", obs_a, obs_b);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    checks++;
    if ({obs_a, obs_b} !== {model_obs(ma, 10), model_obs(mb, 2)}) begin
      failures++;
      $display("FAIL reset_idle got a=%h b=%h exp 000", obs_a, obs_b);
    end
  endtask

  task automatic test_encrypt();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= 11; i++) begin
      if (i > 0) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if ({obs_a, obs_b} !== {model_obs(ma, 10), model_obs(mb, 2)}) begin
        failures++;
        $display("FAIL enc_seq step=%0d got a=%h b=%h exp a=%h b=%h",
                 i, obs_a, obs_b, model_obs(ma, 10), model_obs(mb, 2));
      end
    end
    checks++;
    if ({q_a, round_a, done_a} !== {4'h8, 4'd10, 1'b1}) begin
      failures++;
      $display("FAIL enc_latency got q=%h round=%0d done=%b exp q=8 round=10 done=1",
               q_a, round_a, done_a);
    end
  endtask

  task automatic test_ack_hold();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if ({q_a, round_a, q_b, round_b} !== {4'h8, 4'd10, 4'h8, 4'd2}) begin
        failures++;
        $display("FAIL ack_hold step=%0d got a=%h/%0d b=%h/%0d exp a=8/10 b=8/2",
                 i, q_a, round_a, q_b, round_b);
      end
    end
    tick(1'b1, 1'b1, 1'b1);
    checks++;
    if ({obs_a, obs_b} !== 20'd0) begin
      failures++;
      $display("FAIL ack_release got a=%h b=%h exp 000", obs_a, obs_b);
    end
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if ({obs_a, obs_b} !== {model_obs(ma, 10), model_obs(mb, 2)}) begin
      failures++;
      $display("FAIL ack_start_ignored got a=%h b=%h exp 000", obs_a, obs_b);
    end
  endtask

  task automatic test_decrypt();
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i <= 11; i++) begin
      if (i > 0) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if ({obs_a, obs_b} !== {model_obs(ma, 10), model_obs(mb, 2)}) begin
        failures++;
        $display("FAIL dec_seq step=%0d got a=%h b=%h exp a=%h b=%h",
                 i, obs_a, obs_b, model_obs(ma, 10), model_obs(mb, 2));
      end
    end
    checks++;
    if ({q_a, round_a, done_a, busy_a} !== {4'h9, 4'd10, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL dec_latency got q=%h round=%0d exp q=9 round=10", q_a, round_a);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mode_toggle();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if ({obs_a, obs_b} !== {model_obs(ma, 10), model_obs(mb, 2)}) begin
        failures++;
        $display("FAIL mode_toggle step=%0d got a=%h b=%h exp a=%h b=%h",
                 i, obs_a, obs_b, model_obs(ma, 10), model_obs(mb, 2));
      end
    end
    checks++;
    if (q_a !== 4'h8) begin
      failures++;
      $display("FAIL mode_toggle_end got q=%h exp q=8", q_a);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic md;
    bit   hit = 0;
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !hit; i++) begin
      if (q_a === 4'h6 && round_a === 4'd5) hit = 1;
      else tick(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL arst_reach got q=%h round=%0d exp q=6 round=5", q_a, round_a);
    end
    #2;
    rst = 1'b0;
    #1;
    ma = '{default: 0};
    mb = '{default: 0};
    checks++;
    if ({obs_a, obs_b} !== 20'd0) begin
      failures++;
      $display("FAIL arst_immediate got a=%h b=%h exp 000", obs_a, obs_b);
    end
    @(negedge clk);
    rst = 1'b1;
    md = 1'($urandom_range(0, 1));
    tick(1'b1, md, 1'b0);
    checks++;
    if ({q_a, q_b} !== (md ? 8'h44 : 8'h11)) begin
      failures++;
      $display("FAIL arst_restart got a=%h b=%h mode=%b", q_a, q_b, md);
    end
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_illegal();
    logic [3:0] exp_q [4];
    logic [3:0] exp_r [4];
    exp_q = '{4'h4, 4'h5, 4'h7, 4'h9};
    exp_r = '{4'd0, 4'd1, 4'd2, 4'd2};
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    force dut_a.r_state = state_t'(4'b1100);
    force dut_b.r_state = state_t'(4'b1100);
    #1;
    release dut_a.r_state;
    release dut_b.r_state;
    tick(1'b0, 1'b0, 1'b0);
    ma = '{default: 0};
    mb = '{default: 0};
    checks++;
    if ({obs_a, obs_b} !== 20'd0) begin
      failures++;
      $display("FAIL illegal_recover got a=%h b=%h exp 000", obs_a, obs_b);
    end
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, 1'b1, 1'b0);
      checks++;
      if ({q_b, round_b} !== {exp_q[i], exp_r[i]}) begin
        failures++;
        $display("FAIL nr2_dec step=%0d got q=%h round=%0d exp q=%h round=%0d",
                 i, q_b, round_b, exp_q[i], exp_r[i]);
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      checks++;
      if ({obs_a, obs_b} !== {model_obs(ma, 10), model_obs(mb, 2)}) begin
        failures++;
        $display("FAIL random cyc=%0d got a=%h b=%h exp a=%h b=%h",
                 i, obs_a, obs_b, model_obs(ma, 10), model_obs(mb, 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_ack_hold();
    test_decrypt();
    test_mode_toggle();
    test_async_reset();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
